demux_1x8_sched: RTL and testbench
==================================

Name: demux_1x8_sched

Overview:
- Registered stream scheduler that steers a single input word stream onto eight output channels. It produces the 3-bit select that the 1x8 demux tree consumes and presents the data word on a shared bus.
- Adds valid/ready flow control, a directed mode and a round-robin mode, a per-channel enable mask, and stall-timeout drop handling.
- Sits between an upstream producer and eight downstream consumers.

Parameters:
- DW, 8, data word width.
- TIMEOUT, 16, stall cycles on a held word before it is dropped; legal range 2..255.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream word valid
- in_ready  out  1  scheduler can accept a word
- in_data  in  DW  upstream word
- in_dest  in  3  destination channel (directed mode)
- rr_mode  in  1  1 = round-robin, 0 = directed
- chan_en  in  8  per-channel enable mask
- out_valid  out  8  one-hot valid to channel n
- out_ready  in  8  per-channel ready
- out_data  out  DW  shared data bus, valid for the asserted channel
- sel  out  3  registered channel index of the held word, drives the demux select
- drop_pulse  out  1  one-cycle pulse per dropped word
- drop_cnt  out  8  saturating count of dropped words
- stat_sel  in  3  statistics channel select
- stat_cnt  out  8  delivered count of channel stat_sel

Behaviour:
- Reset (async, rst_n low), all cleared immediately: state IDLE, out_valid 0, out_data 0, sel 0, drop_pulse 0, drop_cnt 0, rr_ptr 0, stall counter 0, stats 0.
- Single-entry output register; FSM states IDLE (empty) and HOLD (word held).
- Handshakes:
  - in_ready = (IDLE or held word completes/drops this cycle) and target available; combinational.
  - Accept = in_valid & in_ready.
  - Delivery = out_valid[sel] & out_ready[sel].
  - Back-to-back accept on the delivery cycle sustains 1 word/cycle.
- Latency: accepted word appears on out_valid/out_data/sel the next cycle.
- out_valid = one-hot(sel) when in HOLD, else 0. Never more than one bit set.
- Directed mode, accepted with in_dest as target:
  - chan_en[in_dest]=1: load, go to HOLD.
  - chan_en[in_dest]=0: word is accepted and discarded. drop_pulse fires next cycle, drop_cnt increments, state unchanged.
- Round-robin mode:
  - Target = first enabled channel scanning upward from rr_ptr with wrap 7->0.
  - On accept, rr_ptr = target+1 (mod 8).
  - chan_en==0: in_ready=0.
- Stall timer:
  - Counts HOLD cycles without delivery; clears on load or delivery.
  - When it reaches TIMEOUT-1 without delivery, that cycle drops the word: HOLD->IDLE (or reload if accepting), drop_pulse, drop_cnt++.
  - Delivery on the same cycle as the timeout wins; no drop.
- Mask changes while in HOLD do not affect the held word; it still waits for delivery or timeout.
- drop_cnt saturates at 255. Drops in consecutive cycles each count.
- rr_mode change takes effect on the next accept only.

Optional Feature:
- DEMUX_SCHED_STATS_EN defined:
  - Eight 8-bit wrapping counters, channel n incremented on each delivery to n.
  - stat_cnt = counter[stat_sel], combinational.
  - Counters cleared by reset.
- DEMUX_SCHED_STATS_EN undefined: no counters; stat_cnt tied to 0.

Test Plan:
- Directed basic: rr_mode=0, chan_en=FF, send 0xA5 to dest 5 with out_ready=FF -> next cycle out_valid=0x20, sel=5, out_data=A5. Delivered that cycle; in_ready stays 1.
- Round-robin skip: rr_mode=1, chan_en=0x91, out_ready=FF, 5 back-to-back words -> channel order 0,4,7,0,4 at 1 word/cycle.
- Disabled destination: chan_en=0xFE, directed word to dest 0 -> accepted, out_valid stays 0, drop_pulse once, drop_cnt=1.
- Timeout: TIMEOUT=16, word to dest 3, out_ready[3]=0 -> out_valid[3] high 15 cycles, then IDLE, drop_pulse, drop_cnt=1. Repeat with ready raised on the 15th cycle -> delivered, no drop.
- Reset mid-operation: rst_n low while in HOLD -> out_valid=0, sel=0, drop_cnt=0 immediately, with no clock edge needed.
- Stats (macro on): 3 deliveries to ch2, 1 to ch6 -> stat_sel=2 reads 3, stat_sel=6 reads 1. Macro off -> stat_cnt reads 0.

Source files
------------

// File: rtl/demux_1x8_sched.sv
// Registered 1x8 stream scheduler: directed/round-robin steering, enable mask, stall-timeout drop.
// Optional per-channel delivery counters under `DEMUX_SCHED_STATS_EN.
module demux_1x8_sched #(
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [2:0]    in_dest,
  input  logic          rr_mode,
  input  logic [7:0]    chan_en,
  output logic [7:0]    out_valid,
  input  logic [7:0]    out_ready,
  output logic [DW-1:0] out_data,
  output logic [2:0]    sel,
  output logic          drop_pulse,
  output logic [7:0]    drop_cnt,
  input  logic [2:0]    stat_sel,
  output logic [7:0]    stat_cnt
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t     state, state_nxt;
  logic [2:0] rr_ptr;
  logic [7:0] stall;
  logic [2:0] target;
  logic [2:0] idx;
  logic       deliver, tout, avail, accept, load, discard;
  logic [8:0] drop_sum;

  // Round-robin target: lowest enabled offset from rr_ptr wins (loop runs high to low).
  always_comb begin
    target = in_dest;
    idx    = '0;
    if (rr_mode) begin
      target = rr_ptr;
      for (int i = 7; i >= 0; i--) begin
        idx = rr_ptr + 3'(i);
        if (chan_en[idx]) target = idx;
      end
    end
  end

  assign deliver  = (state == HOLD) && out_ready[sel];
  // The stall count would reach TIMEOUT-1 at the end of this cycle.
  assign tout     = (state == HOLD) && !deliver && (stall == 8'(TIMEOUT - 2));
  assign avail    = rr_mode ? (|chan_en) : 1'b1;
  assign in_ready = ((state == IDLE) || deliver || tout) && avail;
  assign accept   = in_valid && in_ready;
  assign load     = accept && chan_en[target];
  assign discard  = accept && !chan_en[target];
  assign drop_sum = {1'b0, drop_cnt} + 9'(tout) + 9'(discard);

  assign out_valid = (state == HOLD) ? (8'b1 << sel) : 8'b0;

  always_comb begin
    state_nxt = state;
    if (load)                state_nxt = HOLD;
    else if (deliver || tout) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel        <= '0;
      out_data   <= '0;
      rr_ptr     <= '0;
      stall      <= '0;
      drop_pulse <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      drop_pulse <= tout || discard;
      drop_cnt   <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      if (load) begin
        sel      <= target;
        out_data <= in_data;
      end
      if (accept && rr_mode) rr_ptr <= target + 3'd1;
      if (load || deliver || tout) stall <= '0;
      else if (state == HOLD)      stall <= stall + 8'd1;
    end
  end

`ifdef DEMUX_SCHED_STATS_EN
  logic [7:0] stats [8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) stats[i] <= '0;
    end else if (deliver) begin
      stats[sel] <= stats[sel] + 8'd1;
    end
  end

  assign stat_cnt = stats[stat_sel];
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel;
  assign stat_cnt        = '0;
`endif

endmodule

// File: tb/tb_demux_1x8_sched.sv
// Self-checking bench for demux_1x8_sched: directed scenarios then randomized traffic vs. a reference model.
module tb_demux_1x8_sched;
  localparam int DW      = 8;
  localparam int TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [2:0]    in_dest;
  logic          rr_mode;
  logic [7:0]    chan_en;
  logic [7:0]    out_valid;
  logic [7:0]    out_ready;
  logic [DW-1:0] out_data;
  logic [2:0]    sel;
  logic          drop_pulse;
  logic [7:0]    drop_cnt;
  logic [2:0]    stat_sel;
  logic [7:0]    stat_cnt;

  always #5 clk = ~clk;

  demux_1x8_sched #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dest(in_dest), .rr_mode(rr_mode), .chan_en(chan_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .sel(sel),
    .drop_pulse(drop_pulse), .drop_cnt(drop_cnt), .stat_sel(stat_sel), .stat_cnt(stat_cnt)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: one held word with its channel, data and how long it has been presented.
  bit          m_held;
  int          m_ch;
  logic [7:0]  m_data;
  int          m_age;
  bit          m_dpulse;
  int          m_dcnt;
  int          m_rr;
  int          m_stats [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_held = 0; m_ch = 0; m_data = '0; m_age = 0; m_dpulse = 0; m_dcnt = 0; m_rr = 0;
    for (int i = 0; i < 8; i++) m_stats[i] = 0;
  endtask

  function automatic int m_target();
    if (!rr_mode) return int'(in_dest);
    for (int i = 0; i < 8; i++)
      if (chan_en[(m_rr + i) % 8]) return (m_rr + i) % 8;
    return m_rr;
  endfunction

  function automatic logic [31:0] exp_stat(input logic [2:0] s);
`ifdef DEMUX_SCHED_STATS_EN
    return 32'(m_stats[s]);
`else
    return 32'(s) & 32'd0;
`endif
  endfunction

  // Called shortly after a falling edge with inputs stable; checks, advances one clock, returns at next falling edge.
  task automatic cycle();
    int tgt, drops;
    bit dlv, tmo, rdy, acc;
    tgt = m_target();
    dlv = m_held && out_ready[m_ch];
    tmo = m_held && !dlv && (m_age + 1 == TIMEOUT - 1);
    rdy = (!m_held || dlv || tmo) && (!rr_mode || chan_en != 8'h00);
    acc = in_valid && rdy;
    chk("in_ready",   32'(in_ready),   32'(rdy));
    chk("out_valid",  32'(out_valid),  m_held ? 32'(1 << m_ch) : 32'd0);
    chk("sel",        32'(sel),        32'(m_ch));
    chk("out_data",   32'(out_data),   32'(m_data));
    chk("drop_pulse", 32'(drop_pulse), 32'(m_dpulse));
    chk("drop_cnt",   32'(drop_cnt),   32'(m_dcnt));
    chk("stat_cnt",   32'(stat_cnt),   exp_stat(stat_sel));
    @(posedge clk);
    drops = int'(tmo) + int'(acc && !chan_en[tgt]);
    m_dpulse = (drops > 0);
    m_dcnt = (m_dcnt + drops > 255) ? 255 : m_dcnt + drops;
    if (dlv) m_stats[m_ch] = (m_stats[m_ch] + 1) % 256;
    if (acc && rr_mode) m_rr = (tgt + 1) % 8;
    if (acc && chan_en[tgt]) begin
      m_held = 1; m_ch = tgt; m_data = in_data; m_age = 0;
    end else if (dlv || tmo) begin
      m_held = 0; m_age = 0;
    end else if (m_held) begin
      m_age++;
    end
    @(negedge clk);
  endtask

  task automatic step();
    #1;
    cycle();
  endtask

  int q[$];
  int exp_rr [5] = '{0, 4, 7, 0, 4};
  int hi, seen, rp;

  initial begin
    rst_n = 1'b0; in_valid = 0; in_data = '0; in_dest = '0; rr_mode = 0;
    chan_en = 8'hFF; out_ready = 8'hFF; stat_sel = '0;
    m_reset();
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sel",       32'(sel),       32'd0);
    chk("rst_drop_cnt",  32'(drop_cnt),  32'd0);
    chk("rst_data",      32'(out_data),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed basic
    in_valid = 1; in_data = 8'hA5; in_dest = 3'd5;
    step();
    in_valid = 0;
    #1;
    chk("dir_out_valid", 32'(out_valid), 32'h20);
    chk("dir_sel",       32'(sel),       32'd5);
    chk("dir_data",      32'(out_data),  32'hA5);
    chk("dir_in_ready",  32'(in_ready),  32'd1);
    cycle();
    step();

    // Round-robin skip over mask 0x91
    rr_mode = 1; chan_en = 8'h91; out_ready = 8'hFF;
    for (int i = 0; i < 6; i++) begin
      in_valid = (i < 5); in_data = 8'(8'h10 + i);
      #1;
      if (out_valid != 8'h00) q.push_back(int'(sel));
      cycle();
    end
    chk("rr_count", 32'(q.size()), 32'd5);
    for (int i = 0; i < 5 && i < q.size(); i++) chk("rr_order", 32'(q[i]), 32'(exp_rr[i]));

    // Disabled directed destination
    rr_mode = 0; chan_en = 8'hFE; in_valid = 1; in_dest = 3'd0; in_data = 8'h3C;
    step();
    in_valid = 0;
    #1;
    chk("dis_pulse",     32'(drop_pulse), 32'd1);
    chk("dis_out_valid", 32'(out_valid),  32'd0);
    chk("dis_drop_cnt",  32'(drop_cnt),   32'd1);
    cycle();
    step();

    // Timeout with channel 3 stalled
    chan_en = 8'hFF; out_ready = 8'hF7; in_valid = 1; in_dest = 3'd3; in_data = 8'h77;
    step();
    in_valid = 0; hi = 0; seen = 0;
    for (int k = 0; k < 30; k++) begin
      #1;
      if (out_valid[3]) hi++;
      if (drop_pulse) seen++;
      cycle();
    end
    chk("to_hold_cycles", 32'(hi),       32'd15);
    chk("to_pulses",      32'(seen),     32'd1);
    chk("to_drop_cnt",    32'(drop_cnt), 32'd2);

    // Ready raised on the last presentation cycle: delivered, no drop
    in_valid = 1; in_data = 8'h88;
    step();
    in_valid = 0;
    for (int k = 1; k <= 15; k++) begin
      out_ready = (k == 15) ? 8'hFF : 8'hF7;
      step();
    end
    #1;
    chk("late_out_valid", 32'(out_valid),  32'd0);
    chk("late_pulse",     32'(drop_pulse), 32'd0);
    chk("late_drop_cnt",  32'(drop_cnt),   32'd2);
    cycle();

    // Asynchronous reset while holding
    out_ready = 8'h00; in_valid = 1; in_dest = 3'd6; in_data = 8'h66;
    step();
    in_valid = 0;
    #1;
    chk("pre_rst_valid", 32'(out_valid), 32'h40);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_sel",       32'(sel),       32'd0);
    chk("arst_drop_cnt",  32'(drop_cnt),  32'd0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 8'hFF;

    // Delivery statistics
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_dest = (i < 3) ? 3'd2 : 3'd6; in_data = 8'(i);
      step();
    end
    in_valid = 0;
    step();
    stat_sel = 3'd2;
    #1;
    chk("stat_ch2", 32'(stat_cnt), exp_stat(3'd2));
`ifdef DEMUX_SCHED_STATS_EN
    chk("stat_ch2_abs", 32'(stat_cnt), 32'd3);
`else
    chk("stat_ch2_off", 32'(stat_cnt), 32'd0);
`endif
    stat_sel = 3'd6;
    #1;
`ifdef DEMUX_SCHED_STATS_EN
    chk("stat_ch6_abs", 32'(stat_cnt), 32'd1);
`else
    chk("stat_ch6_off", 32'(stat_cnt), 32'd0);
`endif
    cycle();

    // Randomized traffic
    rp = 1;
    for (int n = 0; n < 600; n++) begin
      if (n % 50 == 0) rp = $urandom_range(0, 3);
      if (n % 16 == 0) begin
        case ($urandom_range(0, 5))
          0:       chan_en = 8'h00;
          1:       chan_en = 8'hFF;
          default: chan_en = 8'($urandom);
        endcase
      end
      if ($urandom_range(0, 31) == 0) rr_mode = 1'($urandom);
      out_ready = (rp == 0) ? 8'h00 : (rp == 1) ? 8'hFF : 8'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      in_dest   = 3'($urandom);
      stat_sel  = 3'($urandom);
      step();
    end

    // Drop counter saturation: every word discarded
    rr_mode = 0; chan_en = 8'h00; in_valid = 1;
    for (int n = 0; n < 260; n++) begin
      in_dest = 3'($urandom);
      step();
    end
    in_valid = 0;
    #1;
    chk("sat_drop_cnt", 32'(drop_cnt), 32'd255);
    cycle();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
